// File: rtl/tape_scope_arbiter.sv
// Single-port sample RAM arbiter: scanout reads win, captures queue in a small FIFO.
// Optional macro SCOPE_DROP_CNT_EN enables the saturating dropped-capture counter.
module tape_scope_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_video,
    input  logic              reset,
    input  logic              cap_req,
    input  logic [7:0]        cap_data,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [7:0]        disp_data,
    output logic              disp_valid,
    input  logic              clear,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout
);

    localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]  FullCnt  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state;
    logic [ADDR_W-1:0] clear_ptr;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              rd_p1;
    logic              rd_p2;

    logic             clear_start;
    logic             do_pop;
    logic             do_push;
    logic             do_drop;
    logic [IDX_W-1:0] fifo_waddr;

    always_comb begin
        clear_start = (state == StIdle) && clear;
        do_pop      = !disp_req && (state == StIdle) && !clear && (fifo_cnt != '0);
        // The clear flush empties the FIFO, so a same-cycle capture always fits.
        do_push     = cap_req && ((fifo_cnt != FullCnt) || do_pop || clear_start);
        do_drop     = cap_req && !do_push;
        fifo_waddr  = clear_start ? '0 : wr_idx;
    end

    always_ff @(posedge clk_video) begin
        if (do_push) begin
            fifo_mem[fifo_waddr] <= cap_data;
        end
    end

    always_ff @(posedge clk_video) begin
        if (reset) begin
            state      <= StIdle;
            busy       <= 1'b0;
            clear_ptr  <= '0;
            wr_ptr     <= '0;
            overflow   <= 1'b0;
            rd_idx     <= '0;
            wr_idx     <= '0;
            fifo_cnt   <= '0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
            ram_addr   <= '0;
            ram_din    <= 8'h00;
            ram_we     <= 1'b0;
        end else begin
            // Read pipeline: address out, RAM latency, capture into disp_data.
            rd_p1      <= disp_req;
            rd_p2      <= rd_p1;
            disp_valid <= rd_p2;
            if (rd_p2) begin
                disp_data <= ram_dout;
            end

            ram_we <= 1'b0;
            if (disp_req) begin
                ram_addr <= disp_addr;
            end else if (state == StClear) begin
                ram_addr  <= clear_ptr;
                ram_din   <= 8'h00;
                ram_we    <= 1'b1;
                clear_ptr <= clear_ptr + ADDR_W'(1);
                if (clear_ptr == LastAddr) begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            end else if (do_pop) begin
                ram_addr <= wr_ptr;
                ram_din  <= fifo_mem[rd_idx];
                ram_we   <= 1'b1;
                wr_ptr   <= wr_ptr + ADDR_W'(1);
            end

            if (clear_start) begin
                state     <= StClear;
                busy      <= 1'b1;
                clear_ptr <= '0;
                wr_ptr    <= '0;
                overflow  <= 1'b0;
                rd_idx    <= '0;
                wr_idx    <= IDX_W'(cap_req);
                fifo_cnt  <= CNT_W'(cap_req);
            end else begin
                if (do_push) begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
                if (do_pop) begin
                    rd_idx <= rd_idx + IDX_W'(1);
                end
                fifo_cnt <= fifo_cnt + CNT_W'(do_push) - CNT_W'(do_pop);
                if (do_drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef SCOPE_DROP_CNT_EN
    always_ff @(posedge clk_video) begin
        if (reset || clear_start) begin
            drop_cnt <= 8'h00;
        end else if (do_drop && (drop_cnt != 8'hff)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_tape_scope_arbiter.sv
// Scoreboard bench for tape_scope_arbiter: RAM writes and scanout reads are checked
// in order against queues filled as stimulus is driven.
module tb_tape_scope_arbiter;

    localparam int AW = 8;

    logic          clk_video = 1'b0;
    logic          reset = 1'b1;
    logic          cap_req = 1'b0;
    logic [7:0]    cap_data = 8'h00;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          clear = 1'b0;
    logic [7:0]    disp_data;
    logic          disp_valid;
    logic          busy;
    logic [AW-1:0] wr_ptr;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout = 8'h00;

    logic [7:0] mem [256];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_t;

    wr_t        wq[$];
    rd_t        rq[$];
    wr_t        mon_w;
    rd_t        mon_r;
    logic [7:0] exp_wr = 8'h00;
    logic       timed_out;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;

    tape_scope_arbiter #(
        .ADDR_W    (AW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_video (clk_video),
        .reset     (reset),
        .cap_req   (cap_req),
        .cap_data  (cap_data),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_valid(disp_valid),
        .clear     (clear),
        .busy      (busy),
        .wr_ptr    (wr_ptr),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    always #5 clk_video = ~clk_video;

    // Synchronous single-port RAM, read data one cycle after the address.
    always @(posedge clk_video) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(negedge clk_video) begin
        if (ram_we === 1'b1) begin
            n_checks = n_checks + 1;
            if (wq.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL ram_write: got %h@%h, required no write", ram_din, ram_addr);
            end else begin
                mon_w = wq.pop_front();
                if ({ram_addr, ram_din} !== {mon_w.addr, mon_w.data}) begin
                    n_fail = n_fail + 1;
                    $display("FAIL ram_write: got %h@%h, required %h@%h",
                             ram_din, ram_addr, mon_w.data, mon_w.addr);
                end
            end
        end
        if (disp_valid === 1'b1) begin
            n_checks = n_checks + 1;
            if (rq.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL disp_read: got %h at cycle %0d, required no data", disp_data, cyc);
            end else begin
                mon_r = rq.pop_front();
                if (disp_data !== mon_r.data || cyc != mon_r.due) begin
                    n_fail = n_fail + 1;
                    $display("FAIL disp_read: got %h at cycle %0d, required %h at cycle %0d",
                             disp_data, cyc, mon_r.data, mon_r.due);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_video);
        cap_req  = 1'b0;
        disp_req = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_cap(input logic [7:0] d, input logic keep);
        cap_req  = 1'b1;
        cap_data = d;
        if (keep) begin
            wq.push_back('{exp_wr, d});
            exp_wr = exp_wr + 8'h01;
        end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d);
        disp_req  = 1'b1;
        disp_addr = a;
        rq.push_back('{d, cyc + 3});
    endtask

    task automatic drain(input int budget);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (wq.size() == 0 && rq.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk_video);
        end
    endtask

    function automatic logic [7:0] wrap_data(input int k);
        logic [8:0] v;
        v = 9'(k);
        return v[8:1] ^ v[7:0];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks = n_checks + 1;
        if ({disp_data, disp_valid, busy, overflow, drop_cnt} !== 19'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_status: got %h/%b/%b/%b/%h, required all zero",
                     disp_data, disp_valid, busy, overflow, drop_cnt);
        end
        n_checks = n_checks + 1;
        if (wr_ptr !== 8'h00) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_wr_ptr: got %h, required 00", wr_ptr);
        end
        n_checks = n_checks + 1;
        if ({ram_addr, ram_din, ram_we} !== 17'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_ram_port: got %h/%h/%b, required zero", ram_addr, ram_din, ram_we);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_capture();
        logic seen;
        seen = 1'b0;
        do_cap(8'hA5, 1'b1);
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            if (ram_we === 1'b1) seen = 1'b1;
        end
        n_checks = n_checks + 1;
        if (seen !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL single_capture_write: got no write, required write within 3 cycles");
        end
        step();
        n_checks = n_checks + 1;
        if (wr_ptr !== 8'h01) begin
            n_fail = n_fail + 1;
            $display("FAIL single_capture_wr_ptr: got %h, required 01", wr_ptr);
        end
    endtask

    task automatic test_disp_priority();
        do_cap(8'h3C, 1'b1);
        step();
        do_read(8'h10, 8'h5A);
        step();
        n_checks = n_checks + 1;
        if (ram_we !== 1'b0 || ram_addr !== 8'h10) begin
            n_fail = n_fail + 1;
            $display("FAIL priority_read_grant: got we=%b addr=%h, required we=0 addr=10",
                     ram_we, ram_addr);
        end
        step();
        n_checks = n_checks + 1;
        if (ram_we !== 1'b1 || ram_addr !== 8'h01) begin
            n_fail = n_fail + 1;
            $display("FAIL priority_deferred_write: got we=%b addr=%h, required we=1 addr=01",
                     ram_we, ram_addr);
        end
        drain(10);
        n_checks = n_checks + 1;
        if (timed_out !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL priority_drain: got timeout, required empty scoreboard");
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_drop;
`ifdef SCOPE_DROP_CNT_EN
        exp_drop = 8'd2;
`else
        exp_drop = 8'd0;
`endif
        for (int k = 0; k < 8; k++) begin
            do_read(8'h80, 8'h00);
            if (k < 6) do_cap(8'((k + 1) * 17), k < 4);
            step();
        end
        n_checks = n_checks + 1;
        if (overflow !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL overflow_flag: got %b, required 1", overflow);
        end
        n_checks = n_checks + 1;
        if (drop_cnt !== exp_drop) begin
            n_fail = n_fail + 1;
            $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, exp_drop);
        end
        drain(40);
        n_checks = n_checks + 1;
        if (timed_out !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL overflow_drain: got timeout, required 4 writes");
        end
        n_checks = n_checks + 1;
        if (overflow !== 1'b1 || wr_ptr !== 8'h06) begin
            n_fail = n_fail + 1;
            $display("FAIL overflow_after_drain: got ovf=%b wr_ptr=%h, required 1/06",
                     overflow, wr_ptr);
        end
    endtask

    task automatic test_clear();
        int  busy_cycles;
        int  reads;
        logic done;
        busy_cycles = 0;
        reads = 0;
        done = 1'b0;
        exp_wr = 8'h00;
        for (int i = 0; i < 256; i++) wq.push_back('{8'(i), 8'h00});
        clear = 1'b1;
        do_cap(8'h77, 1'b1);
        step();
        n_checks = n_checks + 1;
        if ({busy, wr_ptr, overflow, drop_cnt} !== {1'b1, 8'h00, 1'b0, 8'h00}) begin
            n_fail = n_fail + 1;
            $display("FAIL clear_entry: got busy=%b wr_ptr=%h ovf=%b drop=%h, required 1/00/0/00",
                     busy, wr_ptr, overflow, drop_cnt);
        end
        for (int k = 0; k < 700 && !done; k++) begin
            if (busy === 1'b1) begin
                busy_cycles++;
                if (k >= 9 && k % 3 == 0) begin
                    do_read(8'h00, 8'h00);
                    reads++;
                end
                if (k == 50) clear = 1'b1;
                if (k == 100) do_cap(8'hC3, 1'b1);
                step();
            end else begin
                done = 1'b1;
            end
        end
        n_checks = n_checks + 1;
        if (done !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL clear_end: got busy stuck high, required busy to fall");
        end
        n_checks = n_checks + 1;
        if (busy_cycles != 256 + reads) begin
            n_fail = n_fail + 1;
            $display("FAIL clear_duration: got %0d busy cycles, required %0d",
                     busy_cycles, 256 + reads);
        end
        drain(40);
        n_checks = n_checks + 1;
        if (timed_out !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL clear_drain: got timeout, required all clear and queued writes");
        end
        for (int i = 0; i < 256; i++) begin
            do_read(8'(i), (i == 0) ? 8'h77 : (i == 1) ? 8'hC3 : 8'h00);
            step();
        end
        drain(10);
        n_checks = n_checks + 1;
        if (timed_out !== 1'b0 || wr_ptr !== 8'h02) begin
            n_fail = n_fail + 1;
            $display("FAIL clear_readback: got timeout=%b wr_ptr=%h, required 0/02",
                     timed_out, wr_ptr);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_wr = 8'h00;
        for (int k = 1; k <= 257; k++) begin
            do_cap(wrap_data(k), 1'b1);
            step();
        end
        drain(40);
        n_checks = n_checks + 1;
        if (timed_out !== 1'b0 || wr_ptr !== 8'h01) begin
            n_fail = n_fail + 1;
            $display("FAIL wrap_wr_ptr: got timeout=%b wr_ptr=%h, required 0/01", timed_out, wr_ptr);
        end
        do_read(8'h00, wrap_data(257));
        step();
        drain(10);
        n_checks = n_checks + 1;
        if (timed_out !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL wrap_readback: got timeout, required read of address 0");
        end
    endtask

    task automatic test_reset_mid_clear();
        logic any_we;
        any_we = 1'b0;
        for (int i = 0; i < 256; i++) wq.push_back('{8'(i), 8'h00});
        clear = 1'b1;
        step();
        repeat (128) step();
        reset = 1'b1;
        step();
        n_checks = n_checks + 1;
        if ({busy, wr_ptr, ram_we} !== 10'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_mid_clear: got busy=%b wr_ptr=%h we=%b, required 0/00/0",
                     busy, wr_ptr, ram_we);
        end
        reset = 1'b0;
        wq.delete();
        exp_wr = 8'h00;
        repeat (3) begin
            step();
            if (ram_we !== 1'b0) any_we = 1'b1;
        end
        n_checks = n_checks + 1;
        if (any_we !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_fifo_empty: got a write, required none after reset");
        end
        do_cap(8'h9E, 1'b1);
        step();
        drain(10);
        step();
        n_checks = n_checks + 1;
        if (timed_out !== 1'b0 || wr_ptr !== 8'h01) begin
            n_fail = n_fail + 1;
            $display("FAIL post_reset_capture: got timeout=%b wr_ptr=%h, required 0/01",
                     timed_out, wr_ptr);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A;
        test_reset();
        test_single_capture();
        test_disp_priority();
        test_overflow();
        test_clear();
        test_wrap();
        test_reset_mid_clear();
        n_checks = n_checks + 1;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL leftover: got %0d writes %0d reads pending, required 0",
                     wq.size(), rq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
